// File: rtl/id_operand_stage_if.sv
// Signal bundle between the decode operand stage and its neighbours
// (ID issue, regfile read port, MEM/WB bypass sources, EX handshake).
interface id_operand_stage_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [AW-1:0]    id_dst;
  logic             id_we;
  logic             id_is_load;
  logic             id_ready;
  logic [AW-1:0]    rf_rs;
  logic [AW-1:0]    rf_rt;
  logic [DW-1:0]    rf_rs_data;
  logic [DW-1:0]    rf_rt_data;
  logic             mem_valid;
  logic             mem_we;
  logic             mem_is_load;
  logic [AW-1:0]    mem_rd;
  logic [DW-1:0]    mem_wd;
  logic             wb_we;
  logic [AW-1:0]    wb_rd;
  logic [DW-1:0]    wb_wd;
  logic             ex_stall;
  logic             flush;
  logic             ex_valid;
  logic [DW-1:0]    ex_rs_val;
  logic [DW-1:0]    ex_rt_val;
  logic [AW-1:0]    ex_dst;
  logic             ex_we;
  logic             ex_is_load;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_we, id_is_load,
    output rf_rs_data, rf_rt_data,
    output mem_valid, mem_we, mem_is_load, mem_rd, mem_wd,
    output wb_we, wb_rd, wb_wd, ex_stall, flush,
    input  id_ready, rf_rs, rf_rt,
    input  ex_valid, ex_rs_val, ex_rt_val, ex_dst, ex_we, ex_is_load, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_we, id_is_load,
    input  rf_rs_data, rf_rt_data,
    input  mem_valid, mem_we, mem_is_load, mem_rd, mem_wd,
    input  wb_we, wb_rd, wb_wd, ex_stall, flush,
    output id_ready, rf_rs, rf_rt,
    output ex_valid, ex_rs_val, ex_rt_val, ex_dst, ex_we, ex_is_load, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-stage operand read: regfile addressing, MEM/WB bypass, RAW stall
// detection, ID/EX pipeline register and a saturating stall counter.
module id_operand_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  id_operand_stage_if.slave bus
);
  logic             ex_valid_reg;
  logic             ex_we_reg;
  logic             ex_is_load_reg;
  logic [AW-1:0]    ex_dst_reg;
  logic [DW-1:0]    ex_rs_val_reg;
  logic [DW-1:0]    ex_rt_val_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [1:0][AW-1:0] src;
  logic [1:0]         src_used;
  logic [1:0][DW-1:0] rf_data;
  logic [1:0][DW-1:0] opnd;
  logic [1:0]         src_haz;
  logic               hazard;

  assign src      = {bus.id_rt, bus.id_rs};
  assign src_used = {bus.id_uses_rt, bus.id_uses_rs};
  assign rf_data  = {bus.rf_rt_data, bus.rf_rs_data};

  // Index 0 is rs, index 1 is rt; both sources share identical resolution logic.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic is_zero;
      logic live;
      logic mem_fwd;
      logic wb_fwd;
      logic ex_dep;
      logic load_dep;

      assign is_zero  = (src[gi] == '0);
      assign live     = src_used[gi] && !is_zero;
      assign mem_fwd  = bus.mem_valid && bus.mem_we && !bus.mem_is_load && (bus.mem_rd == src[gi]);
      assign wb_fwd   = bus.wb_we && (bus.wb_rd == src[gi]);
      // Producer still in EX, or a load in MEM whose data only exists at WB.
      assign ex_dep   = ex_valid_reg && ex_we_reg && (ex_dst_reg == src[gi]);
      assign load_dep = bus.mem_valid && bus.mem_we && bus.mem_is_load && (bus.mem_rd == src[gi]);

      assign src_haz[gi] = live && (ex_dep || load_dep);
      assign opnd[gi]    = is_zero ? '0 :
                           mem_fwd ? bus.mem_wd :
                           wb_fwd  ? bus.wb_wd  : rf_data[gi];
    end
  endgenerate

  assign hazard       = bus.id_valid && (|src_haz);
  assign bus.id_ready = !hazard && !bus.ex_stall && !bus.flush;
  assign bus.rf_rs    = bus.id_rs;
  assign bus.rf_rt    = bus.id_rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_we_reg      <= 1'b0;
      ex_is_load_reg <= 1'b0;
      ex_dst_reg     <= '0;
      ex_rs_val_reg  <= '0;
      ex_rt_val_reg  <= '0;
    end else if (bus.flush) begin
      ex_valid_reg   <= 1'b0;
      ex_we_reg      <= 1'b0;
      ex_is_load_reg <= 1'b0;
    end else if (bus.ex_stall) begin
      ex_valid_reg   <= ex_valid_reg;
    end else if (bus.id_valid && !hazard) begin
      ex_valid_reg   <= 1'b1;
      ex_we_reg      <= bus.id_we;
      ex_is_load_reg <= bus.id_is_load;
      ex_dst_reg     <= bus.id_dst;
      ex_rs_val_reg  <= opnd[0];
      ex_rt_val_reg  <= opnd[1];
    end else begin
      ex_valid_reg   <= 1'b0;
      ex_we_reg      <= 1'b0;
      ex_is_load_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (hazard && !bus.ex_stall && !bus.flush && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.ex_valid   = ex_valid_reg;
  assign bus.ex_we      = ex_we_reg;
  assign bus.ex_is_load = ex_is_load_reg;
  assign bus.ex_dst     = ex_dst_reg;
  assign bus.ex_rs_val  = ex_rs_val_reg;
  assign bus.ex_rt_val  = ex_rt_val_reg;
  assign bus.stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: bypass priority, ALU and load-use
// stalls, flush, r0 handling, EX hold and reset mid-stall.
module tb_id_operand_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_operand_stage_if #(.DW(32), .AW(5), .CNT_W(16)) bus ();

  id_operand_stage #(.DW(32), .AW(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_dst = 0; bus.id_we = 0; bus.id_is_load = 0;
    bus.rf_rs_data = 0; bus.rf_rt_data = 0;
    bus.mem_valid = 0; bus.mem_we = 0; bus.mem_is_load = 0; bus.mem_rd = 0; bus.mem_wd = 0;
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_wd = 0;
    bus.ex_stall = 0; bus.flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] dst, input logic we, input logic ld);
    bus.id_valid = 1; bus.id_rs = rs; bus.id_uses_rs = urs; bus.id_rt = rt; bus.id_uses_rt = urt;
    bus.id_dst = dst; bus.id_we = we; bus.id_is_load = ld;
  endtask

  task automatic set_mem(input logic v, input logic ld, input logic [4:0] rd, input logic [31:0] wd);
    bus.mem_valid = v; bus.mem_we = v; bus.mem_is_load = ld; bus.mem_rd = rd; bus.mem_wd = wd;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_wd = wd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_all();
    rst = 1;
    tick();
    tick();
    check("rst_ex_valid", 32'(bus.ex_valid), 0);
    check("rst_ex_we", 32'(bus.ex_we), 0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    check("idle_id_ready", 32'(bus.id_ready), 1);
    rst = 0;

    // Same-cycle WB write wins over stale regfile data
    issue(5'd5, 1, 5'd0, 0, 5'd7, 1, 0);
    bus.rf_rs_data = 32'h11;
    set_wb(1, 5'd5, 32'hAA);
    #1 check("rf_rs_addr", 32'(bus.rf_rs), 5);
    tick();
    check("wb_bypass_rs", bus.ex_rs_val, 32'hAA);
    check("wb_bypass_dst", 32'(bus.ex_dst), 7);

    // MEM bypass has priority over WB bypass
    issue(5'd5, 0, 5'd3, 1, 5'd0, 0, 0);
    bus.rf_rt_data = 32'h99;
    set_mem(1, 0, 5'd3, 32'h33);
    set_wb(1, 5'd3, 32'h44);
    tick();
    check("mem_over_wb_rt", bus.ex_rt_val, 32'h33);
    check("nonwriter_ex_we", 32'(bus.ex_we), 0);

    // ALU dependency at distance 1: one bubble, then MEM bypass
    set_mem(0, 0, 5'd0, 0);
    set_wb(0, 5'd0, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd2, 1, 0);
    tick();
    issue(5'd2, 1, 5'd0, 0, 5'd8, 1, 0);
    bus.rf_rs_data = 32'hDEAD;
    #1 check("alu_dep_ready", 32'(bus.id_ready), 0);
    tick();
    check("alu_bubble_valid", 32'(bus.ex_valid), 0);
    check("alu_bubble_we", 32'(bus.ex_we), 0);
    check("alu_stall_cnt", 32'(bus.stall_cnt), 1);
    set_mem(1, 0, 5'd2, 32'h2222_2222);
    #1 check("alu_resume_ready", 32'(bus.id_ready), 1);
    tick();
    check("alu_mem_bypass", bus.ex_rs_val, 32'h2222_2222);
    check("alu_capture_valid", 32'(bus.ex_valid), 1);

    // Load-use: two stall cycles, then WB bypass
    set_mem(0, 0, 5'd0, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    tick();
    check("load_ex_is_load", 32'(bus.ex_is_load), 1);
    issue(5'd0, 0, 5'd4, 1, 5'd9, 1, 0);
    bus.rf_rt_data = 32'h1234;
    #1 check("load_stall1_ready", 32'(bus.id_ready), 0);
    tick();
    set_mem(1, 1, 5'd4, 32'hBAD);
    #1 check("load_stall2_ready", 32'(bus.id_ready), 0);
    tick();
    check("load_bubble_valid", 32'(bus.ex_valid), 0);
    check("load_stall_cnt", 32'(bus.stall_cnt), 3);
    set_mem(0, 0, 5'd0, 0);
    set_wb(1, 5'd4, 32'h4444);
    tick();
    check("load_wb_bypass", bus.ex_rt_val, 32'h4444);
    check("load_after_cnt", 32'(bus.stall_cnt), 3);

    // Load-use again, flushed during the second stall cycle
    set_wb(0, 5'd0, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    tick();
    issue(5'd0, 0, 5'd4, 1, 5'd9, 1, 0);
    tick();
    set_mem(1, 1, 5'd4, 32'hBAD);
    bus.flush = 1;
    #1 check("flush_ready", 32'(bus.id_ready), 0);
    tick();
    bus.flush = 0;
    check("flush_ex_valid", 32'(bus.ex_valid), 0);
    check("flush_ex_we", 32'(bus.ex_we), 0);
    check("flush_stall_cnt", 32'(bus.stall_cnt), 4);

    // r0 producers never stall or bypass
    set_mem(0, 0, 5'd0, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    tick();
    issue(5'd0, 1, 5'd0, 1, 5'd5, 1, 0);
    set_mem(1, 1, 5'd0, 32'hFF);
    set_wb(1, 5'd0, 32'hFF);
    bus.rf_rs_data = 32'h55;
    bus.rf_rt_data = 32'h55;
    #1 check("r0_ready", 32'(bus.id_ready), 1);
    tick();
    check("r0_rs_val", bus.ex_rs_val, 0);
    check("r0_rt_val", bus.ex_rt_val, 0);
    check("r0_stall_cnt", 32'(bus.stall_cnt), 4);

    // EX stall holds the register; a pending hazard is not counted
    set_mem(0, 0, 5'd0, 0);
    set_wb(0, 5'd0, 0);
    issue(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    bus.rf_rs_data = 32'h77;
    bus.ex_stall = 1;
    #1 check("hold_ready", 32'(bus.id_ready), 0);
    for (int i = 0; i < 3; i++) tick();
    check("hold_rs_val", bus.ex_rs_val, 0);
    check("hold_dst", 32'(bus.ex_dst), 5);
    check("hold_valid", 32'(bus.ex_valid), 1);
    check("hold_stall_cnt", 32'(bus.stall_cnt), 4);

    // Reset while a hazard is pending
    bus.ex_stall = 0;
    #1 check("pre_rst_ready", 32'(bus.id_ready), 0);
    rst = 1;
    tick();
    rst = 0;
    check("midstall_rst_valid", 32'(bus.ex_valid), 0);
    check("midstall_rst_cnt", 32'(bus.stall_cnt), 0);
    #1 check("post_rst_ready", 32'(bus.id_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
